// File: rtl/mem_stage_ctrl_pkg.sv
// ============================================================================
// mem_stage_ctrl_pkg
// ----------------------------------------------------------------------------
// Shared types for the MIPS memory-stage controller:
//   word_t       32-bit datapath word
//   mem_state_t  memory-stage FSM state (IDLE / WAIT / HALTED)
//   res_sel_t    selector for the word handed to MEM/WB as the stage result
//   sat_inc()    saturating increment used by the stall-cycle statistic
// ============================================================================
package mem_stage_ctrl_pkg;

    typedef logic [31:0] word_t;

    localparam word_t STALL_SAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'b00,
        MEM_WAIT   = 2'b01,
        MEM_HALTED = 2'b10
    } mem_state_t;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_SC   = 2'b10
    } res_sel_t;

    function automatic word_t sat_inc(input word_t v);
        return (v == STALL_SAT) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_link_reg.sv
// ============================================================================
// link_reg
// ----------------------------------------------------------------------------
// LL/SC link register and address comparator. Only instantiated by
// mem_stage_ctrl when LL_SC_EN is defined.
//
// Ports:
//   clk_i         core clock, rising edge
//   rst_ni        asynchronous active-low reset (link becomes invalid)
//   ll_done_i     an LL completes this cycle (sets the link)
//   sc_done_i     an SC completes this cycle, pass or fail (clears the link)
//   addr_i        address of the instruction in EX/MEM
//   snoop_inv_i   coherence invalidate seen this cycle
//   snoop_addr_i  invalidated address
//   sc_ok_o       link valid and matching addr_i
// ============================================================================
module link_reg
    import mem_stage_ctrl_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  ll_done_i,
    input  logic  sc_done_i,
    input  word_t addr_i,
    input  logic  snoop_inv_i,
    input  word_t snoop_addr_i,
    output logic  sc_ok_o
);

    logic  link_valid_q, link_valid_d;
    word_t link_addr_q,  link_addr_d;

    always_comb begin
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;
        if (ll_done_i) begin
            // A snoop hitting the address being linked in the same cycle wins.
            link_valid_d = !(snoop_inv_i && (snoop_addr_i == addr_i));
            link_addr_d  = addr_i;
        end else if (sc_done_i) begin
            link_valid_d = 1'b0;
        end else if (snoop_inv_i && (snoop_addr_i == link_addr_q)) begin
            link_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
        end else begin
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
        end
    end

    assign sc_ok_o = link_valid_q && (link_addr_q == addr_i);

endmodule

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// mem_stage_ctrl
// ----------------------------------------------------------------------------
// Memory-stage controller between EX/MEM and MEM/WB. Issues data-memory
// requests, stalls the front of the pipe and bubbles MEM/WB while a request
// waits for dhit, selects the stage result and counts stall cycles.
//
// Optional feature macro: LL_SC_EN
//   defined   : LL/SC link register (link_reg) is built; SC is conditional
//   undefined : LL is a plain load, SC an unconditional store returning 1,
//               snoop inputs are ignored. Ports are identical in both builds.
//
// Ports:
//   CLK, nRST                clock / asynchronous active-low reset
//   valid_EX_MEM             EX/MEM holds a real instruction
//   memread/memwrite_EX_MEM  load / store
//   is_ll/is_sc_EX_MEM       LL / SC
//   halt_EX_MEM              HALT
//   result_EX_MEM            ALU result, memory address
//   dmemstore_EX_MEM         store data
//   dhit, dmemload           cache completion and load data
//   snoop_inv, snoop_addr    coherence invalidate
//   dmemREN/WEN/addr/store   request to the cache
//   mem_stall                freeze PC, IF/ID, ID/EX, EX/MEM
//   enable_MEM_WB            MEM/WB enable
//   flush_MEM_WB             MEM/WB captures a bubble
//   mem_result               stage result for MEM/WB
//   stall_cycles             saturating stall-cycle count
// ============================================================================
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  valid_EX_MEM,
    input  logic  memread_EX_MEM,
    input  logic  memwrite_EX_MEM,
    input  logic  is_ll_EX_MEM,
    input  logic  is_sc_EX_MEM,
    input  logic  halt_EX_MEM,
    input  word_t result_EX_MEM,
    input  word_t dmemstore_EX_MEM,
    input  logic  dhit,
    input  word_t dmemload,
    input  logic  snoop_inv,
    input  word_t snoop_addr,
    output logic  dmemREN,
    output logic  dmemWEN,
    output word_t dmemaddr,
    output word_t dmemstore,
    output logic  mem_stall,
    output logic  enable_MEM_WB,
    output logic  flush_MEM_WB,
    output word_t mem_result,
    output word_t stall_cycles
);

    mem_state_t state_q;
    word_t      stall_cnt_q, stall_cnt_d;

    logic     active;
    logic     mem_op;
    logic     sc_ok;
    logic     access;
    res_sel_t res_sel;

    assign active = (state_q != MEM_HALTED);
    assign mem_op = valid_EX_MEM && (memread_EX_MEM || memwrite_EX_MEM);

    // A failing SC issues no request and is not an access.
    assign access = active && mem_op && !(is_sc_EX_MEM && !sc_ok);

`ifdef LL_SC_EN
    logic sc_ok_live;
    logic ll_done;
    logic sc_done;

    assign ll_done = access && memread_EX_MEM && is_ll_EX_MEM && dhit;
    assign sc_done = active && valid_EX_MEM && is_sc_EX_MEM && (!access || dhit);

    link_reg u_link_reg (
        .clk_i        (CLK),
        .rst_ni       (nRST),
        .ll_done_i    (ll_done),
        .sc_done_i    (sc_done),
        .addr_i       (result_EX_MEM),
        .snoop_inv_i  (snoop_inv),
        .snoop_addr_i (snoop_addr),
        .sc_ok_o      (sc_ok_live)
    );

    // Only a passing SC can reach WAIT, so the pass is held there even if a
    // snoop clears the link mid-access; keeps the request stable until dhit.
    assign sc_ok = (state_q == MEM_WAIT) || sc_ok_live;
`else
    logic unused_llsc;
    assign unused_llsc = ^{is_ll_EX_MEM, snoop_inv, snoop_addr};
    assign sc_ok       = 1'b1;
`endif

    // Requests
    assign dmemREN   = access && memread_EX_MEM;
    assign dmemWEN   = access && memwrite_EX_MEM;
    assign dmemaddr  = result_EX_MEM;
    assign dmemstore = dmemstore_EX_MEM;

    // Pipeline control
    assign mem_stall     = access && !dhit;
    assign enable_MEM_WB = active;
    assign flush_MEM_WB  = mem_stall;

    // Result select
    always_comb begin
        res_sel = RES_ALU;
        if (is_sc_EX_MEM)        res_sel = RES_SC;
        else if (memread_EX_MEM) res_sel = RES_LOAD;
    end

    always_comb begin
        mem_result = result_EX_MEM;
        unique case (res_sel)
            RES_SC:   mem_result = {31'b0, sc_ok};
            RES_LOAD: mem_result = dmemload;
            default:  mem_result = result_EX_MEM;
        endcase
    end

    // Stall statistic
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (mem_stall) stall_cnt_d = sat_inc(stall_cnt_q);
    end

    assign stall_cycles = stall_cnt_q;

    // FSM and counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= MEM_IDLE;
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            unique case (state_q)
                MEM_IDLE: begin
                    if (access && !dhit)
                        state_q <= MEM_WAIT;
                    else if (valid_EX_MEM && halt_EX_MEM && !access)
                        state_q <= MEM_HALTED;
                end
                MEM_WAIT: begin
                    if (dhit) state_q <= MEM_IDLE;
                end
                MEM_HALTED: begin
                    state_q <= MEM_HALTED;
                end
                default: state_q <= MEM_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

`ifdef LL_SC_EN
    localparam bit LLSC_BUILD = 1'b1;
`else
    localparam bit LLSC_BUILD = 1'b0;
`endif
    // Failing-SC expectations (a "failing" SC is unconditional without LL/SC)
    localparam logic  SCF_WEN = LLSC_BUILD ? 1'b0 : 1'b1;
    localparam word_t SCF_RES = LLSC_BUILD ? 32'd0 : 32'd1;

    logic  CLK = 1'b0;
    logic  nRST = 1'b0;
    logic  valid_EX_MEM = 1'b0, memread_EX_MEM = 1'b0, memwrite_EX_MEM = 1'b0;
    logic  is_ll_EX_MEM = 1'b0, is_sc_EX_MEM = 1'b0, halt_EX_MEM = 1'b0;
    word_t result_EX_MEM = '0, dmemstore_EX_MEM = '0;
    logic  dhit = 1'b0;
    word_t dmemload = '0;
    logic  snoop_inv = 1'b0;
    word_t snoop_addr = '0;
    logic  dmemREN, dmemWEN, mem_stall, enable_MEM_WB, flush_MEM_WB;
    word_t dmemaddr, dmemstore, mem_result, stall_cycles;

    mem_stage_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .valid_EX_MEM(valid_EX_MEM), .memread_EX_MEM(memread_EX_MEM),
        .memwrite_EX_MEM(memwrite_EX_MEM), .is_ll_EX_MEM(is_ll_EX_MEM),
        .is_sc_EX_MEM(is_sc_EX_MEM), .halt_EX_MEM(halt_EX_MEM),
        .result_EX_MEM(result_EX_MEM), .dmemstore_EX_MEM(dmemstore_EX_MEM),
        .dhit(dhit), .dmemload(dmemload),
        .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_stall(mem_stall),
        .enable_MEM_WB(enable_MEM_WB), .flush_MEM_WB(flush_MEM_WB),
        .mem_result(mem_result), .stall_cycles(stall_cycles)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int    errors = 0;
    int    checks = 0;
    word_t exp_stalls = '0;
    // Reference link model (used only in the LL/SC build)
    logic  m_valid = 1'b0;
    word_t m_addr = '0;

    typedef struct {
        logic  v, rd, wr, ll, sc, hlt;
        word_t a, d;
        logic  hit;
        word_t ld;
        logic  eren, ewen, estall, een;
        word_t eres;
    } vec_t;

    function automatic vec_t mk(input logic v, rd, wr, ll, sc, hlt,
                                input word_t a, d, input logic hit, input word_t ld,
                                input logic eren, ewen, estall, input word_t eres,
                                input logic een = 1'b1);
        vec_t t;
        t.v = v; t.rd = rd; t.wr = wr; t.ll = ll; t.sc = sc; t.hlt = hlt;
        t.a = a; t.d = d; t.hit = hit; t.ld = ld;
        t.eren = eren; t.ewen = ewen; t.estall = estall; t.een = een; t.eres = eres;
        return t;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle (called at a falling edge), check, advance to next falling edge.
    task automatic apply(input string name, input vec_t t);
        valid_EX_MEM = t.v; memread_EX_MEM = t.rd; memwrite_EX_MEM = t.wr;
        is_ll_EX_MEM = t.ll; is_sc_EX_MEM = t.sc; halt_EX_MEM = t.hlt;
        result_EX_MEM = t.a; dmemstore_EX_MEM = t.d; dhit = t.hit; dmemload = t.ld;
        #1;
        chk({name, " dmemREN"}, {31'b0, dmemREN}, {31'b0, t.eren});
        chk({name, " dmemWEN"}, {31'b0, dmemWEN}, {31'b0, t.ewen});
        chk({name, " mem_stall"}, {31'b0, mem_stall}, {31'b0, t.estall});
        chk({name, " flush_MEM_WB"}, {31'b0, flush_MEM_WB}, {31'b0, t.estall});
        chk({name, " enable_MEM_WB"}, {31'b0, enable_MEM_WB}, {31'b0, t.een});
        chk({name, " mem_result"}, mem_result, t.eres);
        chk({name, " stall_cycles"}, stall_cycles, exp_stalls);
        if (t.eren || t.ewen) chk({name, " dmemaddr"}, dmemaddr, t.a);
        if (t.ewen) chk({name, " dmemstore"}, dmemstore, t.d);
        if (t.estall) exp_stalls++;
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        valid_EX_MEM = 1'b0; memread_EX_MEM = 1'b0; memwrite_EX_MEM = 1'b0;
        is_ll_EX_MEM = 1'b0; is_sc_EX_MEM = 1'b0; halt_EX_MEM = 1'b0;
        dhit = 1'b0; snoop_inv = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        exp_stalls = '0;
        m_valid = 1'b0;
    endtask

    // Randomised instruction stream against the reference model.
    task automatic run_random(input int n_instr);
        word_t addrs [3];
        int    kind, lat, ncyc;
        word_t a, d, ld;
        logic  v, rd, wr, ll, sc, ok, acc, hit;
        word_t eres;
        addrs[0] = 32'h300; addrs[1] = 32'h304; addrs[2] = 32'h308;
        for (int n = 0; n < n_instr; n++) begin
            kind = $urandom_range(5, 0);
            lat  = $urandom_range(3, 0);
            a    = addrs[$urandom_range(2, 0)];
            d    = $urandom;
            v = 1'b1; rd = 1'b0; wr = 1'b0; ll = 1'b0; sc = 1'b0;
            case (kind)
                0: rd = 1'b1;                       // LW
                1: wr = 1'b1;                       // SW
                2: begin rd = 1'b1; ll = 1'b1; end  // LL
                3: begin wr = 1'b1; sc = 1'b1; end  // SC
                4: ;                                // ALU op
                default: begin v = 1'b0; rd = $urandom_range(1, 0); wr = !rd; end
            endcase
            ok   = LLSC_BUILD ? (m_valid && (m_addr == a)) : 1'b1;
            acc  = v && (rd || wr) && !(sc && !ok);
            ncyc = acc ? lat + 1 : 1;
            for (int c = 0; c < ncyc; c++) begin
                hit        = acc ? (c == lat) : 1'($urandom_range(1, 0));
                snoop_inv  = ($urandom_range(3, 0) == 0);
                snoop_addr = addrs[$urandom_range(2, 0)];
                ld         = $urandom;
                eres       = sc ? {31'b0, ok} : (rd ? ld : a);
                apply("rand", mk(v, rd, wr, ll, sc, 1'b0, a, d, hit, ld,
                                 acc && rd, acc && wr, acc && !hit, eres));
                if (LLSC_BUILD) begin
                    if (ll && acc && hit) begin
                        m_valid = !(snoop_inv && snoop_addr == a);
                        m_addr  = a;
                    end else if (sc && v && (!acc || hit)) begin
                        m_valid = 1'b0;
                    end else if (snoop_inv && snoop_addr == m_addr) begin
                        m_valid = 1'b0;
                    end
                end
            end
            snoop_inv = 1'b0;
        end
    endtask

    vec_t tbl [9];

    initial begin
        // Reset state
        idle_inputs();
        @(negedge CLK);
        #1;
        chk("reset stall_cycles", stall_cycles, 32'd0);
        chk("reset dmemREN", {31'b0, dmemREN}, 32'd0);
        chk("reset mem_stall", {31'b0, mem_stall}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // Table: single-cycle behaviour with non-LL/SC instructions
        //             v  rd wr ll sc h  addr          data       hit ld            ren wen stl result
        tbl[0] = mk(1, 1, 0, 0, 0, 0, 32'h100, 32'h0,      1, 32'hDEADBEEF, 1, 0, 0, 32'hDEADBEEF);
        tbl[1] = mk(1, 0, 1, 0, 0, 0, 32'h104, 32'h11,     1, 32'h0,        0, 1, 0, 32'h104);
        tbl[2] = mk(1, 0, 0, 0, 0, 0, 32'h1234, 32'h0,     0, 32'h9,        0, 0, 0, 32'h1234);
        tbl[3] = mk(0, 0, 1, 0, 0, 0, 32'h200, 32'h22,     0, 32'h0,        0, 0, 0, 32'h200);
        tbl[4] = mk(1, 0, 0, 0, 0, 0, 32'h4321, 32'h0,     1, 32'h0,        0, 0, 0, 32'h4321);
        tbl[5] = mk(1, 1, 0, 0, 0, 0, 32'h108, 32'h0,      0, 32'h12345678, 1, 0, 1, 32'h12345678);
        tbl[6] = mk(1, 1, 0, 0, 0, 0, 32'h108, 32'h0,      1, 32'hCAFEF00D, 1, 0, 0, 32'hCAFEF00D);
        tbl[7] = mk(1, 0, 1, 0, 0, 0, 32'h10C, 32'h33,     0, 32'h0,        0, 1, 1, 32'h10C);
        tbl[8] = mk(1, 0, 1, 0, 0, 0, 32'h10C, 32'h33,     1, 32'h0,        0, 1, 0, 32'h10C);
        for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // SW miss, dhit three cycles after the request
        for (int i = 0; i < 3; i++)
            apply("sw_miss", mk(1, 0, 1, 0, 0, 0, 32'h200, 32'hA5, 0, 32'h0, 0, 1, 1, 32'h200));
        apply("sw_done", mk(1, 0, 1, 0, 0, 0, 32'h200, 32'hA5, 1, 32'h0, 0, 1, 0, 32'h200));
        apply("after_sw", mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0));

        // LL, SC pass, second SC
        apply("ll", mk(1, 1, 0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h77, 1, 0, 0, 32'h77));
        apply("sc1", mk(1, 0, 1, 0, 1, 0, 32'h300, 32'h55, 1, 32'h0, 0, 1, 0, 32'd1));
        apply("sc2", mk(1, 0, 1, 0, 1, 0, 32'h300, 32'h55, 1, 32'h0, 0, SCF_WEN, 0, SCF_RES));

        // LL, snoop to linked address, SC
        apply("ll_s", mk(1, 1, 0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h1, 1, 0, 0, 32'h1));
        snoop_inv = 1'b1; snoop_addr = 32'h300;
        apply("snoop", mk(1, 0, 0, 0, 0, 0, 32'h7, 32'h0, 0, 32'h0, 0, 0, 0, 32'h7));
        snoop_inv = 1'b0;
        apply("sc_snooped", mk(1, 0, 1, 0, 1, 0, 32'h300, 32'h55, 1, 32'h0, 0, SCF_WEN, 0, SCF_RES));

        // Snoop to another address leaves the link intact
        apply("ll_o", mk(1, 1, 0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h2, 1, 0, 0, 32'h2));
        snoop_inv = 1'b1; snoop_addr = 32'h304;
        apply("snoop_o", mk(1, 0, 0, 0, 0, 0, 32'h8, 32'h0, 0, 32'h0, 0, 0, 0, 32'h8));
        snoop_inv = 1'b0;
        apply("sc_other", mk(1, 0, 1, 0, 1, 0, 32'h300, 32'h66, 1, 32'h0, 0, 1, 0, 32'd1));

        // LL completing with a same-address snoop: snoop wins
        snoop_inv = 1'b1; snoop_addr = 32'h300;
        apply("ll_race", mk(1, 1, 0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h3, 1, 0, 0, 32'h3));
        snoop_inv = 1'b0;
        apply("sc_race", mk(1, 0, 1, 0, 1, 0, 32'h300, 32'h66, 1, 32'h0, 0, SCF_WEN, 0, SCF_RES));

        // Randomised stream
        run_random(300);

        // HALT behind a missing LW
        apply("lw_m1", mk(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 0, 32'h0, 1, 0, 1, 32'h0));
        apply("lw_m2", mk(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 0, 32'h0, 1, 0, 1, 32'h0));
        apply("lw_hit", mk(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 1, 32'hBEEF, 1, 0, 0, 32'hBEEF));
        apply("halt", mk(1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 1'b1));
        apply("halted_lw", mk(1, 1, 0, 0, 0, 0, 32'h404, 32'h0, 0, 32'h5, 0, 0, 0, 32'h5, 1'b0));
        apply("halted_sw", mk(1, 0, 1, 0, 0, 0, 32'h408, 32'h9, 0, 32'h0, 0, 0, 0, 32'h408, 1'b0));
        apply("halted_lw2", mk(1, 1, 0, 0, 0, 0, 32'h40C, 32'h0, 1, 32'h6, 0, 0, 0, 32'h6, 1'b0));

        // Reset leaves HALTED
        do_reset();
        apply("post_halt_lw", mk(1, 1, 0, 0, 0, 0, 32'h500, 32'h0, 1, 32'hAB, 1, 0, 0, 32'hAB));

        // Reset pulsed mid-WAIT
        apply("ll_r", mk(1, 1, 0, 1, 0, 0, 32'h300, 32'h0, 1, 32'h4, 1, 0, 0, 32'h4));
        apply("sw_r1", mk(1, 0, 1, 0, 0, 0, 32'h600, 32'h1, 0, 32'h0, 0, 1, 1, 32'h600));
        apply("sw_r2", mk(1, 0, 1, 0, 0, 0, 32'h600, 32'h1, 0, 32'h0, 0, 1, 1, 32'h600));
        #2;
        nRST = 1'b0;
        valid_EX_MEM = 1'b0;
        #1;
        chk("mid_wait_reset stall_cycles", stall_cycles, 32'd0);
        chk("mid_wait_reset dmemWEN", {31'b0, dmemWEN}, 32'd0);
        chk("mid_wait_reset mem_stall", {31'b0, mem_stall}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        exp_stalls = '0;
        m_valid = 1'b0;
        apply("sc_after_reset", mk(1, 0, 1, 0, 1, 0, 32'h300, 32'h7, 1, 32'h0, 0, SCF_WEN, 0, SCF_RES));
        apply("lw_after_reset", mk(1, 1, 0, 0, 0, 0, 32'h700, 32'h0, 1, 32'h99, 1, 0, 0, 32'h99));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
